// File: rtl/camera_frame_writer_if.sv
// Pixel-stream input and BRAM write-port bundle for camera_frame_writer.
// slave = the writer itself, master = the pixel source / memory side.
interface camera_frame_writer_if #(
  parameter int ADDR_W = 17
);
  logic              pixel_valid_in;
  logic [10:0]       pixel_hcount_in;
  logic [9:0]        pixel_vcount_in;
  logic [15:0]       pixel_data_in;
  logic              avg_mode_in;
  logic              frame_release_in;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [15:0]       mem_data_out;
  logic              read_bank_out;
  logic              frame_done_out;
  logic [15:0]       frames_dropped_out;
  logic              busy_out;

  modport slave (
    input  pixel_valid_in,
    input  pixel_hcount_in,
    input  pixel_vcount_in,
    input  pixel_data_in,
    input  avg_mode_in,
    input  frame_release_in,
    output mem_we_out,
    output mem_addr_out,
    output mem_data_out,
    output read_bank_out,
    output frame_done_out,
    output frames_dropped_out,
    output busy_out
  );

  modport master (
    output pixel_valid_in,
    output pixel_hcount_in,
    output pixel_vcount_in,
    output pixel_data_in,
    output avg_mode_in,
    output frame_release_in,
    input  mem_we_out,
    input  mem_addr_out,
    input  mem_data_out,
    input  read_bank_out,
    input  frame_done_out,
    input  frames_dropped_out,
    input  busy_out
  );
endinterface

// File: rtl/camera_frame_writer.sv
// Downsampling RGB565 frame-buffer writer with ping-pong banks and
// a frame-complete / release handshake towards the display reader.
module camera_frame_writer #(
  parameter int SRC_WIDTH     = 1280,
  parameter int SRC_HEIGHT    = 720,
  parameter int DS_SHIFT      = 2,
  parameter int DOUBLE_BUFFER = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  camera_frame_writer_if.slave bus
);
  localparam int DST_W    = SRC_WIDTH >> DS_SHIFT;
  localparam int DST_H    = SRC_HEIGHT >> DS_SHIFT;
  localparam int FB_DEPTH = DST_W * DST_H;
  localparam int ADDR_W   = $clog2(FB_DEPTH * (1 + DOUBLE_BUFFER));
  localparam int RW       = 5 + DS_SHIFT;
  localparam int GW       = 6 + DS_SHIFT;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DROP    = 2'd2;

  localparam logic        DB       = (DOUBLE_BUFFER != 0);
  localparam logic [10:0] H_LAST   = 11'(SRC_WIDTH - 1);
  localparam logic [9:0]  V_LAST   = 10'(SRC_HEIGHT - 1);
  localparam logic [10:0] H_MASK   = 11'((1 << DS_SHIFT) - 1);
  localparam logic [9:0]  V_MASK   = 10'((1 << DS_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] BANK_OFS = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(DST_W);

  logic [1:0]        state;
  logic              wbank;
  logic              pending;
  logic              avg_q;
  logic [RW-1:0]     acc_r;
  logic [GW-1:0]     acc_g;
  logic [RW-1:0]     acc_b;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              rbank_q;
  logic              done_q;
  logic [15:0]       dropped_q;

  logic [10:0] h;
  logic [9:0]  v;
  logic [15:0] d;
  assign h = bus.pixel_hcount_in;
  assign v = bus.pixel_vcount_in;
  assign d = bus.pixel_data_in;

  logic accepted;
  logic is_first;
  logic is_last;
  logic drop_now;
  logic cap_now;
  logic mode;
  logic grp_first;
  logic grp_last;
  logic line_ok;
  logic wr_now;

  assign accepted = bus.pixel_valid_in && (h <= H_LAST) && (v <= V_LAST);
  assign is_first = accepted && (h == '0) && (v == '0);
  assign is_last  = accepted && (h == H_LAST) && (v == V_LAST)
                    && (state == S_CAPTURE);

  // A release in the same cycle as a frame start frees the bank first.
  assign drop_now = is_first && DB && pending && !bus.frame_release_in;
  assign cap_now  = is_first ? !drop_now
                             : (accepted && state == S_CAPTURE);
  assign mode     = is_first ? bus.avg_mode_in : avg_q;

  assign grp_first = (h & H_MASK) == '0;
  assign grp_last  = (h & H_MASK) == H_MASK;
  assign line_ok   = (v & V_MASK) == '0;
  assign wr_now    = cap_now && line_ok && (mode ? grp_last : grp_first);

  logic [RW-1:0] sum_r;
  logic [GW-1:0] sum_g;
  logic [RW-1:0] sum_b;
  assign sum_r = (grp_first ? '0 : acc_r) + RW'(d[15:11]);
  assign sum_g = (grp_first ? '0 : acc_g) + GW'(d[10:5]);
  assign sum_b = (grp_first ? '0 : acc_b) + RW'(d[4:0]);

  logic [15:0] wr_data;
  assign wr_data = mode ? {5'(sum_r >> DS_SHIFT),
                           6'(sum_g >> DS_SHIFT),
                           5'(sum_b >> DS_SHIFT)}
                        : d;

  logic [ADDR_W-1:0] wr_addr;
  assign wr_addr = (wbank ? BANK_OFS : '0)
                 + ADDR_W'(v >> DS_SHIFT) * ROW_LEN
                 + ADDR_W'(h >> DS_SHIFT);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      wbank     <= DB;
      pending   <= 1'b0;
      avg_q     <= 1'b0;
      acc_r     <= '0;
      acc_g     <= '0;
      acc_b     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rbank_q   <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= '0;
    end else begin
      we_q   <= wr_now;
      done_q <= is_last;
      if (wr_now) begin
        addr_q <= wr_addr;
        data_q <= wr_data;
      end
      if (cap_now && line_ok) begin
        acc_r <= sum_r;
        acc_g <= sum_g;
        acc_b <= sum_b;
      end
      if (is_first) begin
        avg_q <= bus.avg_mode_in;
        state <= drop_now ? S_DROP : S_CAPTURE;
        if (drop_now && dropped_q != 16'hFFFF)
          dropped_q <= dropped_q + 16'd1;
      end else if (is_last) begin
        state <= S_IDLE;
      end
      if (is_last && DB) begin
        rbank_q <= wbank;
        wbank   <= ~wbank;
        pending <= 1'b1;
      end else if (bus.frame_release_in) begin
        pending <= 1'b0;
      end
    end
  end

  assign bus.mem_we_out         = we_q;
  assign bus.mem_addr_out       = addr_q;
  assign bus.mem_data_out       = data_q;
  assign bus.read_bank_out      = rbank_q;
  assign bus.frame_done_out     = done_q;
  assign bus.frames_dropped_out = dropped_q;
  assign bus.busy_out           = (state == S_CAPTURE);
endmodule

// File: tb/tb_camera_frame_writer.sv
// Bench for camera_frame_writer: a double-buffered and a single-bank
// instance share one pixel stream and are checked against a frame model.
module tb_camera_frame_writer;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid  = 1'b0;
  logic [10:0] hc     = '0;
  logic [9:0]  vc     = '0;
  logic [15:0] pd     = '0;
  logic        avg    = 1'b0;
  logic        rel    = 1'b0;
  bit          armed  = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  camera_frame_writer_if #(.ADDR_W(17)) bus0 ();
  camera_frame_writer_if #(.ADDR_W(16)) bus1 ();

  assign bus0.pixel_valid_in   = valid;
  assign bus0.pixel_hcount_in  = hc;
  assign bus0.pixel_vcount_in  = vc;
  assign bus0.pixel_data_in    = pd;
  assign bus0.avg_mode_in      = avg;
  assign bus0.frame_release_in = rel;
  assign bus1.pixel_valid_in   = valid;
  assign bus1.pixel_hcount_in  = hc;
  assign bus1.pixel_vcount_in  = vc;
  assign bus1.pixel_data_in    = pd;
  assign bus1.avg_mode_in      = avg;
  assign bus1.frame_release_in = rel;

  camera_frame_writer #(
    .SRC_WIDTH(1280), .SRC_HEIGHT(720),
    .DS_SHIFT(2), .DOUBLE_BUFFER(1)
  ) dut0 (.clk_in(clk_in), .rst_in(rst_in), .bus(bus0));

  camera_frame_writer #(
    .SRC_WIDTH(1280), .SRC_HEIGHT(720),
    .DS_SHIFT(2), .DOUBLE_BUFFER(0)
  ) dut1 (.clk_in(clk_in), .rst_in(rst_in), .bus(bus1));

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, $time, act, act, exp, exp);
    end
  endtask

  // Frame model: idx 0 = two banks, idx 1 = single bank.
  // st: 0 idle, 1 capturing, 2 dropping.
  int m_st[2], m_wb[2], m_pend[2], m_av[2];
  int m_rs[2], m_gs[2], m_bs[2];
  int e_we[2], e_addr[2], e_data[2], e_done[2], e_rb[2], e_drop[2];

  always @(posedge clk_in) begin
    for (int i = 0; i < 2; i++) begin : step
      int st, wb, pend, av, rs, gs, bs, we, ad, da, dn, rb, dr;
      int h, v, f;
      bit db, acc;
      db = (i == 0);
      h  = int'(hc);
      v  = int'(vc);
      f  = 4;
      if (rst_in) begin
        st = 0; wb = db ? 1 : 0; pend = 0; av = 0;
        rs = 0; gs = 0; bs = 0;
        we = 0; ad = 0; da = 0; dn = 0; rb = 0; dr = 0;
      end else begin
        st = m_st[i]; wb = m_wb[i]; pend = m_pend[i]; av = m_av[i];
        rs = m_rs[i]; gs = m_gs[i]; bs = m_bs[i];
        ad = e_addr[i]; da = e_data[i]; rb = e_rb[i]; dr = e_drop[i];
        we = 0; dn = 0;
        acc = valid && h < 1280 && v < 720;
        if (rel) pend = 0;
        if (acc && h == 0 && v == 0) begin
          av = int'(avg);
          if (pend != 0 && db) begin
            st = 2;
            if (dr < 65535) dr++;
          end else begin
            st = 1;
          end
        end
        if (acc && st == 1) begin
          if (v % f == 0) begin
            if (av == 0) begin
              if (h % f == 0) begin we = 1; da = int'(pd); end
            end else begin
              if (h % f == 0) begin rs = 0; gs = 0; bs = 0; end
              rs += int'(pd[15:11]);
              gs += int'(pd[10:5]);
              bs += int'(pd[4:0]);
              if (h % f == f - 1) begin
                we = 1;
                da = ((rs / f) << 11) | ((gs / f) << 5) | (bs / f);
              end
            end
            if (we != 0) ad = wb * 57600 + (v / f) * 320 + h / f;
          end
          if (h == 1279 && v == 719) begin
            dn = 1;
            if (db) begin rb = wb; wb = 1 - wb; pend = 1; end
            st = 0;
          end
        end
      end
      m_st[i] <= st; m_wb[i] <= wb; m_pend[i] <= pend; m_av[i] <= av;
      m_rs[i] <= rs; m_gs[i] <= gs; m_bs[i] <= bs;
      e_we[i] <= we; e_addr[i] <= ad; e_data[i] <= da;
      e_done[i] <= dn; e_rb[i] <= rb; e_drop[i] <= dr;
    end
  end

  always @(negedge clk_in) begin
    if (armed) begin
      chk("we0", int'(bus0.mem_we_out), e_we[0]);
      chk("we1", int'(bus1.mem_we_out), e_we[1]);
      if (e_we[0] != 0) begin
        chk("addr0", int'(bus0.mem_addr_out), e_addr[0]);
        chk("data0", int'(bus0.mem_data_out), e_data[0]);
      end
      if (e_we[1] != 0) begin
        chk("addr1", int'(bus1.mem_addr_out), e_addr[1]);
        chk("data1", int'(bus1.mem_data_out), e_data[1]);
        chk("addr1_range", int'(bus1.mem_addr_out < 17'd57600), 1);
      end
      chk("done0", int'(bus0.frame_done_out), e_done[0]);
      chk("done1", int'(bus1.frame_done_out), e_done[1]);
      chk("rbank0", int'(bus0.read_bank_out), e_rb[0]);
      chk("rbank1", int'(bus1.read_bank_out), e_rb[1]);
      chk("drop0", int'(bus0.frames_dropped_out), e_drop[0]);
      chk("drop1", int'(bus1.frames_dropped_out), e_drop[1]);
      chk("busy0", int'(bus0.busy_out), int'(m_st[0] == 1));
      chk("busy1", int'(bus1.busy_out), int'(m_st[1] == 1));
    end
  end

  task automatic send(input int h, input int v, input int d, input bit r);
    @(posedge clk_in); #1;
    valid = 1'b1;
    hc = 11'(h);
    vc = 10'(v);
    pd = 16'(d);
    rel = r;
    @(posedge clk_in); #1;
    valid = 1'b0;
    rel = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    armed = 1'b1;
    rst_in = 1'b0;
    chk("rst_we", int'(bus0.mem_we_out), 0);
    chk("rst_addr", int'(bus0.mem_addr_out), 0);
    chk("rst_data", int'(bus0.mem_data_out), 0);
    chk("rst_rbank", int'(bus0.read_bank_out), 0);
    chk("rst_drop", int'(bus0.frames_dropped_out), 0);
    chk("rst_busy", int'(bus0.busy_out), 0);

    // decimation into bank 1
    avg = 1'b0;
    send(0, 0, 'h1111, 1'b0);
    chk("t1_start_addr", int'(bus0.mem_addr_out), 57600);
    chk("t1_start_addr1", int'(bus1.mem_addr_out), 0);
    send(4, 8, 'hABCD, 1'b0);
    chk("t1_we", int'(bus0.mem_we_out), 1);
    chk("t1_addr", int'(bus0.mem_addr_out), 58241);
    chk("t1_data", int'(bus0.mem_data_out), 'hABCD);
    send(5, 8, 'h0001, 1'b0);
    chk("t1_skip_h", int'(bus0.mem_we_out), 0);
    send(4, 9, 'h0001, 1'b0);
    chk("t1_skip_v", int'(bus0.mem_we_out), 0);
    send(1280, 0, 'h0001, 1'b0);
    chk("t1_out_of_range", int'(bus0.mem_we_out), 0);

    // horizontal averaging, R = 4,8,12,16
    avg = 1'b1;
    send(0, 0, 4 << 11, 1'b0);
    chk("t2_we_h0", int'(bus0.mem_we_out), 0);
    chk("t2_busy", int'(bus0.busy_out), 1);
    send(1, 0, 8 << 11, 1'b0);
    chk("t2_we_h1", int'(bus0.mem_we_out), 0);
    send(2, 0, 12 << 11, 1'b0);
    chk("t2_we_h2", int'(bus0.mem_we_out), 0);
    send(3, 0, 16 << 11, 1'b0);
    chk("t2_we", int'(bus0.mem_we_out), 1);
    chk("t2_addr", int'(bus0.mem_addr_out), 57600);
    chk("t2_data", int'(bus0.mem_data_out), 'h5000);

    // frame end, then a frame with no release
    avg = 1'b0;
    send(1279, 719, 0, 1'b0);
    chk("t3_done", int'(bus0.frame_done_out), 1);
    chk("t3_rbank", int'(bus0.read_bank_out), 1);
    chk("t3_done1", int'(bus1.frame_done_out), 1);
    chk("t3_rbank1", int'(bus1.read_bank_out), 0);
    send(0, 0, 'h3333, 1'b0);
    chk("t3_drop_we", int'(bus0.mem_we_out), 0);
    chk("t3_dropped", int'(bus0.frames_dropped_out), 1);
    chk("t3_busy", int'(bus0.busy_out), 0);
    chk("t6_we1", int'(bus1.mem_we_out), 1);
    chk("t6_addr1", int'(bus1.mem_addr_out), 0);
    send(4, 8, 'h4444, 1'b0);
    chk("t3_drop_we2", int'(bus0.mem_we_out), 0);
    chk("t6_addr1b", int'(bus1.mem_addr_out), 641);
    send(1279, 719, 0, 1'b0);
    chk("t3_no_done", int'(bus0.frame_done_out), 0);
    chk("t6_done1", int'(bus1.frame_done_out), 1);
    chk("t6_rbank1", int'(bus1.read_bank_out), 0);
    chk("t6_drop1", int'(bus1.frames_dropped_out), 0);

    // release coincident with frame start
    send(0, 0, 'h2222, 1'b1);
    chk("t4_we", int'(bus0.mem_we_out), 1);
    chk("t4_addr", int'(bus0.mem_addr_out), 0);
    chk("t4_data", int'(bus0.mem_data_out), 'h2222);
    chk("t4_busy", int'(bus0.busy_out), 1);

    // reset in the middle of a frame
    @(posedge clk_in); #1;
    valid = 1'b1; hc = 11'd100; vc = 10'd40; pd = 16'h0005;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    valid = 1'b0;
    rst_in = 1'b0;
    chk("t5_we", int'(bus0.mem_we_out), 0);
    chk("t5_rbank", int'(bus0.read_bank_out), 0);
    chk("t5_drop", int'(bus0.frames_dropped_out), 0);
    chk("t5_busy", int'(bus0.busy_out), 0);
    send(4, 4, 'h0007, 1'b0);
    chk("t5_idle_we", int'(bus0.mem_we_out), 0);
    chk("t5_idle_we1", int'(bus1.mem_we_out), 0);

    repeat (4) @(posedge clk_in);
    #1;
    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/camera_frame_writer.md
Name: camera_frame_writer

Overview:
Parametrised successor to the fixed 4x camera frame-buffer writer. Accepts the reconstructed RGB565 pixel stream (valid/hcount/vcount/data) from pixel_reconstruct and downsamples by 2^DS_SHIFT in both axes, using either decimation or horizontal box-averaging. Generates registered BRAM write-port signals into an optional ping-pong double buffer. Performs a frame-complete/release handshake with the pixel-side reader so that display never tears.

Parameters:
SRC_WIDTH, 1280, source active width in pixels
SRC_HEIGHT, 720, source active height in lines
DS_SHIFT, 2, downsample factor = 2^DS_SHIFT per axis (range 0..3)
DOUBLE_BUFFER, 1, 1 = two banks with handshake; 0 = single bank, never drops
Derived (localparam):
- DST_W = SRC_WIDTH>>DS_SHIFT
- DST_H = SRC_HEIGHT>>DS_SHIFT
- FB_DEPTH = DST_W*DST_H
- ADDR_W = $clog2(FB_DEPTH*(1+DOUBLE_BUFFER))

Ports:
clk_in  input  1  camera-domain clock
rst_in  input  1  synchronous active-high reset
pixel_valid_in  input  1  pixel strobe from pixel_reconstruct
pixel_hcount_in  input  11  source column
pixel_vcount_in  input  10  source line
pixel_data_in  input  16  RGB565 pixel
avg_mode_in  input  1  0 = decimate, 1 = horizontal average; sampled at frame start
frame_release_in  input  1  1-cycle pulse: reader has switched to the newest bank
mem_we_out  output  1  BRAM write enable
mem_addr_out  output  ADDR_W  BRAM write address
mem_data_out  output  16  BRAM write data (RGB565)
read_bank_out  output  1  bank the reader must display
frame_done_out  output  1  1-cycle pulse: frame fully written and banks swapped
frames_dropped_out  output  16  saturating count of skipped frames
busy_out  output  1  high while in CAPTURE

Behaviour:
- Reset values: mem_we_out=0, mem_addr_out=0, mem_data_out=0, read_bank_out=0, frame_done_out=0, frames_dropped_out=0, busy_out=0. Internal: write bank=1 (0 if DOUBLE_BUFFER=0), reader_pending=0, state=IDLE.
- Accepted pixel: pixel_valid_in=1 with hcount<SRC_WIDTH and vcount<SRC_HEIGHT. All other pixels are ignored.
- Frame start = accepted pixel at (0,0).
- States:
  - IDLE: ignore all pixels except a frame start.
  - CAPTURE: write pixels into the write bank.
  - DROP: discard pixels until the next frame start.
- At frame start, from any state:
  - If reader_pending=1 and DOUBLE_BUFFER=1: go to DROP and increment frames_dropped_out (saturates at 0xFFFF).
  - Otherwise: go to CAPTURE.
  - Latch avg_mode_in in both cases.
  - A frame start seen while in CAPTURE abandons the partial frame: no swap, no frame_done_out.
- frame_release_in clears reader_pending. If release and frame start occur in the same cycle, the release applies first and the frame is captured.
- Decimate mode:
  - Write when hcount[DS_SHIFT-1:0]==0 and vcount[DS_SHIFT-1:0]==0.
  - mem_data_out = pixel_data_in.
- Average mode, only on lines with vcount[DS_SHIFT-1:0]==0:
  - Per-channel accumulators: R and B are 5+DS_SHIFT bits, G is 6+DS_SHIFT bits.
  - Low hcount bits == 0: load the accumulators (no add).
  - Low hcount bits == all-ones: write {Rsum>>S, Gsum>>S, Bsum>>S}, where S = DS_SHIFT.
  - Other low hcount bits: add to the accumulators.
- Write address = bank*FB_DEPTH + (vcount>>S)*DST_W + (hcount>>S).
- All write outputs are registered: mem_we_out is high exactly one cycle after the triggering pixel and is low otherwise.
- Frame end = accepted pixel (SRC_WIDTH-1, SRC_HEIGHT-1) while in CAPTURE. In the next cycle:
  - frame_done_out=1 (coincides with the final write, if any).
  - If DOUBLE_BUFFER=1: read_bank_out takes the old write bank, the write bank toggles, and reader_pending=1.
  - If DOUBLE_BUFFER=0: no bank change.
  - State goes to IDLE.
- DS_SHIFT=0: every accepted pixel is written, and average mode equals decimate mode.
- rst_in asserted mid-frame: next cycle all outputs return to reset values and no writes occur until a new frame start.

Test Plan:
1. Decimate, defaults: reset, frame start, then pixel (4,8) with data 0xABCD -> next cycle we=1, addr=57600+2*320+1=58241, data=0xABCD. Pixels (5,8) and (4,9) -> no write.
2. Average: line 0, hcount 0..3 with R=4,8,12,16 (data=R<<11), G=B=0 -> exactly one write, one cycle after hcount 3: addr=57600, data=0x5000.
3. Full frame, then pixel (1279,719) -> frame_done_out high 1 cycle, read_bank_out 0->1 in that cycle. Next frame with no release -> zero writes, frames_dropped_out=1, busy_out=0.
4. frame_release_in and frame start (0,0) in the same cycle -> CAPTURE; pixel (0,0) write at addr=0 (bank 0).
5. rst_in during CAPTURE at pixel (100,40) -> next cycle we=0, read_bank_out=0, frames_dropped_out=0. Pixel (4,4) before a new frame start -> no write.
6. DOUBLE_BUFFER=0: two full frames with no release -> both captured, all addresses <57600, read_bank_out stays 0, two frame_done_out pulses, frames_dropped_out=0.
